// File: rtl/timer_pkg.sv
// Shared types and saturation helper for the multi-channel countdown timer.
// Used by timer_channel and countdown_timer_mc.
package timer_pkg;

    localparam logic [7:0] SEC_MAX  = 8'd59;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] HOUR_MAX = 8'd23;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } hms_t;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} tmr_state_t;

    function automatic hms_t sat_hms(input hms_t v);
        hms_t r;
        r.hh = (v.hh > HOUR_MAX) ? HOUR_MAX : v.hh;
        r.mm = (v.mm > MIN_MAX)  ? MIN_MAX  : v.mm;
        r.ss = (v.ss > SEC_MAX)  ? SEC_MAX  : v.ss;
        return r;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One HH:MM:SS countdown channel: IDLE/RUN/PAUSE/DONE FSM and counter.
// TIMER_AUTO_RELOAD_EN adds a reload register restored on reaching zero.
module timer_channel
    import timer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clr,
    input  logic        ld,
    input  logic [23:0] ld_val,
    input  logic        start_stop,
    input  logic        tick,
    output logic [23:0] value,
    output logic        running,
    output logic        expired,
    output logic        expire_pulse
);

    tmr_state_t state;
    hms_t       cnt;
    hms_t       dec;
    logic       dec_zero;
    logic       wrap;
    logic       ld_ok;

    assign value = cnt;
    assign ld_ok = ld && (state != RUN);

    always_comb begin
        dec = cnt;
        if (cnt.ss != 8'd0) begin
            dec.ss = cnt.ss - 8'd1;
        end else if (cnt.mm != 8'd0) begin
            dec.mm = cnt.mm - 8'd1;
            dec.ss = SEC_MAX;
        end else begin
            dec.hh = cnt.hh - 8'd1;
            dec.mm = MIN_MAX;
            dec.ss = SEC_MAX;
        end
    end

    assign dec_zero = (dec == '0);

`ifdef TIMER_AUTO_RELOAD_EN
    hms_t rld;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rld <= '0;
        end else if (!clr && ld_ok) begin
            rld <= ld_val;
        end
    end

    assign wrap = (rld != '0);
`else
    hms_t rld;
    assign rld  = '0;
    assign wrap = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            running      <= 1'b0;
            expired      <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            expire_pulse <= 1'b0;
            if (clr) begin
                state   <= IDLE;
                cnt     <= '0;
                running <= 1'b0;
                expired <= 1'b0;
            end else if (ld_ok) begin
                state   <= IDLE;
                cnt     <= ld_val;
                running <= 1'b0;
                expired <= 1'b0;
            end else if (start_stop) begin
                unique case (state)
                    IDLE: begin
                        if (cnt != '0) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else begin
                            state        <= DONE;
                            expired      <= 1'b1;
                            expire_pulse <= 1'b1;
                        end
                    end
                    RUN: begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                    PAUSE: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (tick && state == RUN) begin
                if (dec_zero) begin
                    expired      <= 1'b1;
                    expire_pulse <= 1'b1;
                    if (wrap) begin
                        cnt <= rld;
                    end else begin
                        cnt     <= dec;
                        state   <= DONE;
                        running <= 1'b0;
                    end
                end else begin
                    cnt <= dec;
                end
            end
        end
    end

endmodule

// File: rtl/countdown_timer_mc.sv
// Multi-channel HH:MM:SS countdown timer with shared 1 s prescaler.
// Optional build macro: TIMER_AUTO_RELOAD_EN (per-channel auto reload).
module countdown_timer_mc
    import timer_pkg::*;
#(
    parameter  int N_CH     = 2,
    parameter  int TICK_DIV = 50000000,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              load,
    input  logic [23:0]       load_data,
    input  logic              start_stop,
    input  logic              clear,
    output logic [24*N_CH-1:0] data,
    output logic [N_CH-1:0]   running,
    output logic [N_CH-1:0]   expired,
    output logic [N_CH-1:0]   expire_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre;
    logic          sec_tick;
    hms_t          ld_sat;

    assign sec_tick = (pre == PW'(TICK_DIV - 1));
    assign ld_sat   = sat_hms(load_data);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre <= '0;
        end else if (sec_tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Out-of-range ch_sel never matches any channel index, so it is ignored.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic hit;
        assign hit = (ch_sel == CH_W'(c));

        timer_channel u_ch (
            .clock        (clock),
            .reset        (reset),
            .clr          (hit && clear),
            .ld           (hit && load),
            .ld_val       (ld_sat),
            .start_stop   (hit && start_stop),
            .tick         (sec_tick),
            .value        (data[24*c +: 24]),
            .running      (running[c]),
            .expired      (expired[c]),
            .expire_pulse (expire_pulse[c])
        );
    end

endmodule
